teclado_matricial: RTL and testbench

TECLADO_MATRICIAL -- requirements
Module: teclado_matricial

---
 rtl/teclado_matricial.sv | 188 ++++++++++++++++++
 tb/tb_teclado_matricial.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/teclado_matricial.sv
// 4x4 matrix keypad scanner: drives one column low at a time, synchronizes the
// active-low rows, debounces press and release, and reports the accepted key code.
module teclado_matricial #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic [4:0] digito,
  output logic       cambio_digito,
  output logic       tecla_presionada
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ST_SCAN         = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE     = 3'd1;
  localparam logic [2:0] ST_PRESSED      = 3'd2;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB   = 3'd4;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;
  localparam logic [3:0] COL_FIRST = 4'b1110;
  localparam logic [4:0] NO_KEY    = 5'd16;

  logic [3:0]    fila_meta_q, fila_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [4:0]    digito_q, digito_d;
  logic          cambio_q, cambio_d;
  logic          tecla_q, tecla_d;

  // True when exactly one line of an active-low pattern is asserted.
  function automatic logic one_low(input logic [3:0] p);
    return (p == 4'b1110) || (p == 4'b1101) || (p == 4'b1011) || (p == 4'b0111);
  endfunction

  // Index of the single low bit of a one-cold pattern.
  function automatic logic [1:0] low_index(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    case (p)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad legend: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    code = NO_KEY;
    case ({r, c})
      4'd0:  code = 5'd1;
      4'd1:  code = 5'd2;
      4'd2:  code = 5'd3;
      4'd3:  code = 5'd10;
      4'd4:  code = 5'd4;
      4'd5:  code = 5'd5;
      4'd6:  code = 5'd6;
      4'd7:  code = 5'd11;
      4'd8:  code = 5'd7;
      4'd9:  code = 5'd8;
      4'd10: code = 5'd9;
      4'd11: code = 5'd12;
      4'd12: code = 5'd14;
      4'd13: code = 5'd0;
      4'd14: code = 5'd15;
      4'd15: code = 5'd13;
      default: code = NO_KEY;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fila_meta_q <= ROWS_IDLE;
      fila_s_q    <= ROWS_IDLE;
    end else begin
      fila_meta_q <= fila;
      fila_s_q    <= fila_meta_q;
    end
  end

  // State, counter, latched key position and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SCAN;
      cnt_q    <= '0;
      col_q    <= COL_FIRST;
      row_q    <= ROWS_IDLE;
      digito_q <= NO_KEY;
      cambio_q <= 1'b0;
      tecla_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      digito_q <= digito_d;
      cambio_q <= cambio_d;
      tecla_q  <= tecla_d;
    end
  end

  // Scan/debounce sequencing; the column only rotates when no key is being tracked.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    digito_d = digito_q;
    cambio_d = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (one_low(fila_s_q)) begin
            row_d   = fila_s_q;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (fila_s_q != row_q) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          col_d   = {col_q[2:0], col_q[3]};
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRESSED: begin
        digito_d = key_code(low_index(row_q), low_index(col_q));
        cambio_d = 1'b1;
        state_d  = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (fila_s_q == ROWS_IDLE) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_DB: begin
        if (fila_s_q != ROWS_IDLE) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          col_d   = {col_q[2:0], col_q[3]};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
    tecla_d = (state_d == ST_PRESSED) || (state_d == ST_WAIT_RELEASE) ||
              (state_d == ST_RELEASE_DB);
  end

  assign columna          = col_q;
  assign digito           = digito_q;
  assign cambio_digito    = cambio_q;
  assign tecla_presionada = tecla_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Directed bench for teclado_matricial with a behavioural keypad model.
module tb_teclado_matricial;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [4:0] digito;
  logic       cambio_digito;
  logic       tecla_presionada;

  int n_tests = 0;
  int n_fail  = 0;

  // Keypad model controls.
  bit         key_on   = 1'b0;
  bit         ghost_on = 1'b0;
  logic [1:0] key_r    = 2'd0;
  logic [1:0] key_c    = 2'd0;

  // Monitor state.
  int         pulse_cnt   = 0;
  logic [4:0] pulse_digit = 5'd31;
  int         col_changes = 0;
  int         cold_err    = 0;
  logic [3:0] prev_col    = 4'b1110;

  teclado_matricial #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fila            (fila),
    .columna         (columna),
    .digito          (digito),
    .cambio_digito   (cambio_digito),
    .tecla_presionada(tecla_presionada)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row to its column; ghost drives 1010 on column 0.
  always_comb begin
    fila = 4'b1111;
    if (ghost_on) begin
      if (columna == 4'b1110) fila = 4'b1010;
    end else if (key_on && (columna[key_c] == 1'b0)) begin
      fila[key_r] = 1'b0;
    end
  end

  // Pulse counting, column activity and one-cold check, sampled on falling edge.
  always @(negedge clk) begin
    if (cambio_digito === 1'b1) begin
      pulse_cnt   = pulse_cnt + 1;
      pulse_digit = digito;
    end
    if (columna !== prev_col) col_changes = col_changes + 1;
    prev_col = columna;
    if (!(columna inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) cold_err = cold_err + 1;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (columna !== 4'b1110) begin n_fail++; $display("FAIL reset_col got=%b exp=1110", columna); end
    n_tests++; if (digito !== 5'd16) begin n_fail++; $display("FAIL reset_dig got=%0d exp=16", digito); end
    n_tests++; if (cambio_digito !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", cambio_digito); end
    n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL reset_tecla got=%b exp=0", tecla_presionada); end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++; if (columna !== 4'b1101) begin n_fail++; $display("FAIL scan_advance got=%b exp=1101", columna); end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++; if (columna !== 4'b1110) begin n_fail++; $display("FAIL async_reset_col got=%b exp=1110", columna); end
    n_tests++; if (digito !== 5'd16) begin n_fail++; $display("FAIL async_reset_dig got=%0d exp=16", digito); end
    n_tests++; if (cambio_digito !== 1'b0) begin n_fail++; $display("FAIL async_reset_pulse got=%b exp=0", cambio_digito); end
    repeat (3) @(negedge clk);
    n_tests++; if (columna !== 4'b1110) begin n_fail++; $display("FAIL reset_hold_col got=%b exp=1110", columna); end
    reset = 1'b0;
  endtask

  task automatic test_key5();
    int base;
    base  = pulse_cnt;
    key_r = 2'd1; key_c = 2'd1; key_on = 1'b1;
    repeat (200) @(negedge clk);
    n_tests++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL key5_pulses got=%0d exp=1", pulse_cnt - base); end
    n_tests++; if (pulse_digit !== 5'd5) begin n_fail++; $display("FAIL key5_pulse_dig got=%0d exp=5", pulse_digit); end
    n_tests++; if (tecla_presionada !== 1'b1) begin n_fail++; $display("FAIL key5_held got=%b exp=1", tecla_presionada); end
    key_on = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL key5_release got=%b exp=0", tecla_presionada); end
    n_tests++; if (digito !== 5'd5) begin n_fail++; $display("FAIL key5_dig_hold got=%0d exp=5", digito); end
    n_tests++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL key5_no_repeat got=%0d exp=1", pulse_cnt - base); end
  endtask

  task automatic test_bounce();
    int base;
    base  = pulse_cnt;
    key_r = 2'd2; key_c = 2'd2; key_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_on = ~key_on;
      repeat (3) @(negedge clk);
    end
    n_tests++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL bounce_pulses got=%0d exp=0", pulse_cnt - base); end
    n_tests++; if (digito !== 5'd5) begin n_fail++; $display("FAIL bounce_dig got=%0d exp=5", digito); end
    key_on = 1'b1;
    repeat (50) @(negedge clk);
    n_tests++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL stable9_pulses got=%0d exp=1", pulse_cnt - base); end
    n_tests++; if (digito !== 5'd9) begin n_fail++; $display("FAIL stable9_dig got=%0d exp=9", digito); end
    key_on = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL key9_release got=%b exp=0", tecla_presionada); end
  endtask

  task automatic test_corners();
    logic [1:0] rows [3];
    logic [1:0] cols [3];
    logic [4:0] codes[3];
    int base;
    int c0;
    rows  = '{2'd3, 2'd3, 2'd3};
    cols  = '{2'd2, 2'd3, 2'd0};
    codes = '{5'd15, 5'd13, 5'd14};
    for (int k = 0; k < 3; k++) begin
      base  = pulse_cnt;
      key_r = rows[k]; key_c = cols[k]; key_on = 1'b1;
      repeat (60) @(negedge clk);
      n_tests++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL corner%0d_pulses got=%0d exp=1", k, pulse_cnt - base); end
      n_tests++; if (pulse_digit !== codes[k]) begin n_fail++; $display("FAIL corner%0d_pulse_dig got=%0d exp=%0d", k, pulse_digit, codes[k]); end
      n_tests++; if (digito !== codes[k]) begin n_fail++; $display("FAIL corner%0d_dig got=%0d exp=%0d", k, digito, codes[k]); end
      key_on = 1'b0;
      repeat (30) @(negedge clk);
      n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL corner%0d_release got=%b exp=0", k, tecla_presionada); end
      c0 = col_changes;
      repeat (20) @(negedge clk);
      n_tests++; if (col_changes - c0 < 3) begin n_fail++; $display("FAIL corner%0d_rescan got=%0d changes exp>=3", k, col_changes - c0); end
    end
  endtask

  task automatic test_ghost();
    int base;
    int c0;
    logic [4:0] d0;
    d0   = digito;
    base = pulse_cnt;
    c0   = col_changes;
    ghost_on = 1'b1;
    repeat (60) @(negedge clk);
    n_tests++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL ghost_pulses got=%0d exp=0", pulse_cnt - base); end
    n_tests++; if (digito !== d0) begin n_fail++; $display("FAIL ghost_dig got=%0d exp=%0d", digito, d0); end
    n_tests++; if (col_changes - c0 < 10) begin n_fail++; $display("FAIL ghost_scan got=%0d changes exp>=10", col_changes - c0); end
    n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL ghost_tecla got=%b exp=0", tecla_presionada); end
    ghost_on = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_wait_release();
    int base;
    base  = pulse_cnt;
    key_r = 2'd3; key_c = 2'd1; key_on = 1'b1;
    repeat (60) @(negedge clk);
    n_tests++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL key0_pulses got=%0d exp=1", pulse_cnt - base); end
    n_tests++; if (digito !== 5'd0) begin n_fail++; $display("FAIL key0_dig got=%0d exp=0", digito); end
    n_tests++; if (tecla_presionada !== 1'b1) begin n_fail++; $display("FAIL key0_wait got=%b exp=1", tecla_presionada); end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++; if (digito !== 5'd16) begin n_fail++; $display("FAIL wr_reset_dig got=%0d exp=16", digito); end
    n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL wr_reset_tecla got=%b exp=0", tecla_presionada); end
    n_tests++; if (columna !== 4'b1110) begin n_fail++; $display("FAIL wr_reset_col got=%b exp=1110", columna); end
    repeat (3) @(negedge clk);
    base  = pulse_cnt;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    n_tests++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL wr_repress_pulses got=%0d exp=1", pulse_cnt - base); end
    n_tests++; if (pulse_digit !== 5'd0) begin n_fail++; $display("FAIL wr_repress_pulse_dig got=%0d exp=0", pulse_digit); end
    n_tests++; if (digito !== 5'd0) begin n_fail++; $display("FAIL wr_repress_dig got=%0d exp=0", digito); end
    key_on = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++; if (tecla_presionada !== 1'b0) begin n_fail++; $display("FAIL wr_release got=%b exp=0", tecla_presionada); end
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_corners();
    test_ghost();
    test_reset_wait_release();
    n_tests++; if (cold_err !== 0) begin n_fail++; $display("FAIL columna_one_cold got=%0d bad samples exp=0", cold_err); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
